eth_tx_frame_buffer: RTL and testbench
======================================

// Module: eth_tx_frame_buffer
// PURPOSE
//  Store-and-forward TX frame FIFO between the RISC-V system's eth_tx_axis stream and the
//  QSFP28 MAC TX stream, in the eth_gt_user_clock domain. Forwards a frame only once its
//  last beat is stored, so the MAC never sees a mid-frame underrun. Frames that are aborted
//  (tuser=1 on tlast) or do not fit are discarded whole and counted.
// PARAMETERS
//  ADDR_BITS   9    buffer depth = 2**ADDR_BITS beats of 64 bits (default 512 = 4 KiB)
//  DROP_BITS   16   width of saturating drop counter
// PORTS
//  clock           in   1    eth_gt_user_clock; all logic on rising edge
//  resetn          in   1    asynchronous active-low reset
//  s_axis_tdata    in   64   frame data from RISC-V side
//  s_axis_tkeep    in   8    byte enables; bit i = byte [8i+7:8i]
//  s_axis_tlast    in   1    last beat of frame
//  s_axis_tuser    in   1    1 on tlast beat = abort frame
//  s_axis_tvalid   in   1    input beat valid
//  s_axis_tready   out  1    input ready
//  m_axis_tdata    out  64   data to MAC
//  m_axis_tkeep    out  8    byte enables to MAC
//  m_axis_tlast    out  1    last beat to MAC
//  m_axis_tuser    out  1    underrun/abort to MAC; constant 0
//  m_axis_tvalid   out  1    output beat valid
//  m_axis_tready   in   1    MAC ready
//  tx_frames       out  32   frames fully sent (tlast accepted at output); wraps
//  drop_frames     out  DROP_BITS  frames discarded at input; saturates at all-ones
//  fill_level      out  ADDR_BITS+1  stored beats (committed + in-progress), 0..2**ADDR_BITS
// BEHAVIOUR
//  Reset: all outputs 0; pointers, frame count, counters cleared; write FSM = WRITE.
//  s_axis_tready = 1 from first clock after reset release; never deasserted otherwise
//  (frames that cannot be stored are accepted and dropped, never back-pressured).
//  Storage: RAM word {tkeep,tlast,tdata}; pointers are ADDR_BITS+1 bits (wrap bit);
//  full when wr_ptr - rd_ptr == 2**ADDR_BITS.
//  Write FSM (beat accepted = tvalid & tready):
//   WRITE: beat with buffer not full -> stored, wr_ptr++.
//     tlast & !tuser -> wr_commit <= wr_ptr+1, frame_count++ (commit).
//     tlast & tuser  -> wr_ptr <= wr_commit (rewind), drop_frames++.
//     beat while full: not tlast -> rewind, go DROP; tlast -> rewind, drop_frames++.
//   DROP: discard beats; on tlast -> drop_frames++, go WRITE.
//   Frame longer than 2**ADDR_BITS beats always ends in DROP.
//  Read side: output register fed from synchronous RAM read with one-beat prefetch;
//   read allowed only while rd_ptr != wr_commit. Words become readable 2 clocks after the
//   committing tlast (commit cycle + RAM read); first output beat of an empty-buffer frame
//   appears m_axis_tvalid=1 no later than the 3rd rising edge after the input tlast.
//   Output AXI-S rules: m_axis_tvalid held with stable data until tready; once a frame
//   starts, beats are back-to-back whenever tready=1 (no bubbles, whole frame is stored).
//   Output beat accepted with tlast -> frame_count--, tx_frames++.
//  Simultaneous commit and output tlast in one cycle: frame_count unchanged, both counters
//  update. Rewind never touches committed data (rd_ptr..wr_commit).
//  fill_level = wr_ptr - rd_ptr, updated every cycle; includes uncommitted beats.
//  tkeep stored/forwarded unchanged (including tkeep=0 beats). tuser on non-last beats ignored.
//  Mid-operation reset: partial output frame truncated (m_axis_tvalid drops to 0
//  asynchronously); all stored frames lost; counters cleared.
// TESTING
//  1 Single 8-beat frame, m_tready=1 -> identical 8 beats out, tlast on 8th, tx_frames=1,
//    first m_tvalid within 3 clocks of input tlast, no gaps.
//  2 Frame with tuser=1 on tlast, then a good 4-beat frame -> only 4-beat frame out,
//    drop_frames=1, fill_level returns to 0.
//  3 m_tready=0; send 600-beat frame (ADDR_BITS=9) -> s_tready stays 1, frame dropped,
//    drop_frames=1, fill_level=0, m_tvalid never 1.
//  4 m_tready=0; fill with 7 x 64-beat frames, then 100-beat frame -> 7th commit ok, 8th
//    dropped (fill 448+64 full); release tready -> 7 frames out in order, tx_frames=7.
//  5 m_tready random 50%, 1000 random frames 1..64 beats with random tkeep on tlast ->
//    output stream matches scoreboard; no bubble inside a frame while tready=1.
//  6 Assert resetn mid-output-frame -> m_tvalid=0 same cycle, counters 0; new frame after
//    release passes intact.

Source files
------------

// File: rtl/eth_tx_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_frame_buffer
// Brief    : Store-and-forward 64-bit AXI-Stream TX frame FIFO; a frame is
//            released to the MAC only once its last beat is stored.
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_frame_buffer #(
    parameter int ADDR_BITS = 9,
    parameter int DROP_BITS = 16
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [63:0]          s_axis_tdata,
    input  logic [7:0]           s_axis_tkeep,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [63:0]          m_axis_tdata,
    output logic [7:0]           m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [31:0]          tx_frames,
    output logic [DROP_BITS-1:0] drop_frames,
    output logic [ADDR_BITS:0]   fill_level
);

    localparam int                   c_ptr_w       = ADDR_BITS + 1;
    localparam int                   c_depth_words = 1 << ADDR_BITS;
    localparam logic [c_ptr_w-1:0]   c_depth       = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [c_ptr_w-1:0]   c_ptr_one     = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [DROP_BITS-1:0] c_drop_one    = {{(DROP_BITS-1){1'b0}}, 1'b1};
    localparam logic [DROP_BITS-1:0] c_drop_max    = {DROP_BITS{1'b1}};
    localparam logic [31:0]          c_tx_one      = 32'd1;

    typedef enum logic [0:0] {
        ST_WRITE = 1'b0,
        ST_DROP  = 1'b1
    } wr_state_e;

    wr_state_e            state_q;
    logic                 ready_q;
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_commit_q, rd_ptr_q, frame_count_q;
    logic [DROP_BITS-1:0] drop_q;
    logic [31:0]          tx_q;
    logic [72:0]          mem_q [c_depth_words];
    logic [72:0]          ram_q;
    logic                 ram_v_q;
    logic [63:0]          m_data_q;
    logic [7:0]           m_keep_q;
    logic                 m_last_q, m_valid_q;

    logic [c_ptr_w-1:0]   fill_d;
    logic                 full_d, beat_d;
    logic                 wr_en_d, commit_d, rewind_d, drop_evt_d, go_drop_d, go_write_d;
    logic                 rd_avail_d, out_load_d, rd_issue_d, out_last_acc_d;

    assign fill_d = wr_ptr_q - rd_ptr_q;
    assign full_d = (fill_d == c_depth);
    assign beat_d = s_axis_tvalid && ready_q;

    // Overflowing or aborted frames rewind to the last commit point; committed data is untouched.
    always_comb begin
        wr_en_d    = 1'b0;
        commit_d   = 1'b0;
        rewind_d   = 1'b0;
        drop_evt_d = 1'b0;
        go_drop_d  = 1'b0;
        go_write_d = 1'b0;
        if (beat_d) begin
            if (state_q == ST_WRITE) begin
                if (!full_d) begin
                    wr_en_d = 1'b1;
                    if (s_axis_tlast && s_axis_tuser) begin
                        rewind_d   = 1'b1;
                        drop_evt_d = 1'b1;
                    end else if (s_axis_tlast) begin
                        commit_d = 1'b1;
                    end
                end else begin
                    rewind_d = 1'b1;
                    if (s_axis_tlast) begin
                        drop_evt_d = 1'b1;
                    end else begin
                        go_drop_d = 1'b1;
                    end
                end
            end else if (s_axis_tlast) begin
                drop_evt_d = 1'b1;
                go_write_d = 1'b1;
            end
        end
    end

    // Two-stage read pipeline (RAM register, then output register) keeps stored frames bubble-free.
    assign rd_avail_d     = (rd_ptr_q != wr_commit_q);
    assign out_load_d     = ram_v_q && (!m_valid_q || m_axis_tready);
    assign rd_issue_d     = rd_avail_d && (!ram_v_q || out_load_d);
    assign out_last_acc_d = m_valid_q && m_axis_tready && m_last_q;

    always_ff @(posedge clock) begin
        if (wr_en_d) begin
            mem_q[wr_ptr_q[ADDR_BITS-1:0]] <= {s_axis_tkeep, s_axis_tlast, s_axis_tdata};
        end
        if (rd_issue_d) begin
            ram_q <= mem_q[rd_ptr_q[ADDR_BITS-1:0]];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_WRITE;
            ready_q       <= 1'b0;
            wr_ptr_q      <= '0;
            wr_commit_q   <= '0;
            rd_ptr_q      <= '0;
            frame_count_q <= '0;
            drop_q        <= '0;
            tx_q          <= '0;
            ram_v_q       <= 1'b0;
            m_data_q      <= '0;
            m_keep_q      <= '0;
            m_last_q      <= 1'b0;
            m_valid_q     <= 1'b0;
        end else begin
            ready_q <= 1'b1;

            if (go_drop_d) begin
                state_q <= ST_DROP;
            end else if (go_write_d) begin
                state_q <= ST_WRITE;
            end

            if (rewind_d) begin
                wr_ptr_q <= wr_commit_q;
            end else if (wr_en_d) begin
                wr_ptr_q <= wr_ptr_q + c_ptr_one;
            end
            if (commit_d) begin
                wr_commit_q <= wr_ptr_q + c_ptr_one;
            end

            if (drop_evt_d && (drop_q != c_drop_max)) begin
                drop_q <= drop_q + c_drop_one;
            end

            case ({commit_d, out_last_acc_d})
                2'b10:   frame_count_q <= frame_count_q + c_ptr_one;
                2'b01:   frame_count_q <= frame_count_q - c_ptr_one;
                default: frame_count_q <= frame_count_q;
            endcase

            if (rd_issue_d) begin
                rd_ptr_q <= rd_ptr_q + c_ptr_one;
            end
            if (rd_issue_d) begin
                ram_v_q <= 1'b1;
            end else if (out_load_d) begin
                ram_v_q <= 1'b0;
            end

            if (out_load_d) begin
                m_data_q  <= ram_q[63:0];
                m_last_q  <= ram_q[64];
                m_keep_q  <= ram_q[72:65];
                m_valid_q <= 1'b1;
            end else if (m_axis_tready) begin
                m_valid_q <= 1'b0;
            end

            if (out_last_acc_d) begin
                tx_q <= tx_q + c_tx_one;
            end
        end
    end

    assign s_axis_tready = ready_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tuser  = 1'b0;
    assign m_axis_tvalid = m_valid_q;
    assign tx_frames     = tx_q;
    assign drop_frames   = drop_q;
    assign fill_level    = fill_d;

endmodule

`default_nettype wire

// File: tb/tb_eth_tx_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_frame_buffer
// Brief    : Scoreboard bench for the store-and-forward TX frame buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_tx_frame_buffer;

    localparam int ADDR_BITS = 9;
    localparam int DROP_BITS = 16;

    logic                 clock = 1'b0;
    logic                 resetn = 1'b0;
    logic [63:0]          s_tdata = '0;
    logic [7:0]           s_tkeep = '0;
    logic                 s_tlast = 1'b0;
    logic                 s_tuser = 1'b0;
    logic                 s_tvalid = 1'b0;
    logic                 s_tready;
    logic [63:0]          m_tdata;
    logic [7:0]           m_tkeep;
    logic                 m_tlast, m_tuser, m_tvalid;
    logic                 m_tready = 1'b0;
    logic [31:0]          tx_frames;
    logic [DROP_BITS-1:0] drop_frames;
    logic [ADDR_BITS:0]   fill_level;

    int          checks = 0;
    int          failures = 0;
    int          exp_tx = 0;
    int          exp_drops = 0;
    logic [72:0] sb [$];
    logic [72:0] exp_w;
    bit          rand_ready = 1'b0;
    logic        fixed_ready = 1'b0;
    bit          in_frame = 1'b0;
    bit          saw_valid = 1'b0;
    bit          ready_low = 1'b0;

    eth_tx_frame_buffer #(.ADDR_BITS(ADDR_BITS), .DROP_BITS(DROP_BITS)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .tx_frames     (tx_frames),
        .drop_frames   (drop_frames),
        .fill_level    (fill_level)
    );

    always #5 clock = ~clock;

    // Sink ready changes at posedge+2 so it never races the stimulus written at posedge+1.
    always @(posedge clock) begin
        #2;
        m_tready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
    end

    // Output monitor: compares every accepted beat with the scoreboard head.
    always @(negedge clock) begin
        if (!resetn) begin
            in_frame = 1'b0;
        end else begin
            if (m_tvalid) saw_valid = 1'b1;
            if (in_frame && m_tready) begin
                checks++;
                if (m_tvalid !== 1'b1) begin
                    failures++;
                    $display("FAIL out_bubble: m_axis_tvalid=%b inside a frame with tready=1, required 1", m_tvalid);
                end
            end
            if (m_tvalid && m_tready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL out_unexpected: beat keep=%h last=%b data=%h, none expected", m_tkeep, m_tlast, m_tdata);
                end else begin
                    exp_w = sb.pop_front();
                    if ({m_tkeep, m_tlast, m_tdata} !== exp_w || m_tuser !== 1'b0) begin
                        failures++;
                        $display("FAIL out_beat: got keep=%h last=%b data=%h user=%b, required keep=%h last=%b data=%h user=0",
                                 m_tkeep, m_tlast, m_tdata, m_tuser, exp_w[72:65], exp_w[64], exp_w[63:0]);
                    end
                end
                in_frame = !m_tlast;
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drives one frame at full rate; called and returns at posedge+1.
    task automatic send_frame(input int len, input bit abort, input bit expect_out);
        logic [63:0] d;
        logic [7:0]  k;
        logic        last;
        for (int i = 0; i < len; i++) begin
            d    = {$urandom, $urandom};
            k    = (i % 5 == 3) ? 8'h00 : 8'($urandom);
            last = (i == len - 1);
            s_tdata  = d;
            s_tkeep  = k;
            s_tlast  = last;
            s_tuser  = last ? abort : 1'($urandom_range(0, 1));
            s_tvalid = 1'b1;
            if (expect_out) sb.push_back({k, last, d});
            if (s_tready !== 1'b1) ready_low = 1'b1;
            tick(1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        if (expect_out) exp_tx++;
        else exp_drops++;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d beats still pending after %0d cycles, required 0", name, sb.size(), n);
            sb.delete();
        end
        tick(3);
    endtask

    task automatic check_counters(input string name);
        checks++;
        if (tx_frames !== 32'(exp_tx)) begin
            failures++;
            $display("FAIL %s_tx_frames: got %0d, required %0d", name, tx_frames, exp_tx);
        end
        checks++;
        if (drop_frames !== DROP_BITS'(exp_drops)) begin
            failures++;
            $display("FAIL %s_drop_frames: got %0d, required %0d", name, drop_frames, exp_drops);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(3);
        checks++;
        if ({m_tvalid, s_tready, m_tlast, m_tuser} !== 4'b0000 || m_tdata !== 64'h0 || m_tkeep !== 8'h0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b sready=%b last=%b user=%b data=%h keep=%h, required all 0",
                     m_tvalid, s_tready, m_tlast, m_tuser, m_tdata, m_tkeep);
        end
        checks++;
        if (tx_frames !== 32'd0 || drop_frames !== 16'd0 || fill_level !== 10'd0) begin
            failures++;
            $display("FAIL reset_counters: tx=%0d drop=%0d fill=%0d, required 0/0/0", tx_frames, drop_frames, fill_level);
        end
        resetn = 1'b1;
        tick(1);
        checks++;
        if (s_tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_tready: s_axis_tready=%b one clock after release, required 1", s_tready);
        end
    endtask

    task automatic test_single_frame();
        int lat = 0;
        fixed_ready = 1'b1;
        tick(2);
        send_frame(8, 1'b0, 1'b1);
        for (int k = 1; k <= 5 && lat == 0; k++) begin
            tick(1);
            if (m_tvalid) lat = k;
        end
        checks++;
        if (lat == 0 || lat > 3) begin
            failures++;
            $display("FAIL single_latency: first m_axis_tvalid after %0d edges (0=never), required 1..3", lat);
        end
        wait_drain(100, "single");
        check_counters("single");
    endtask

    task automatic test_abort();
        send_frame(5, 1'b1, 1'b0);
        send_frame(4, 1'b0, 1'b1);
        wait_drain(100, "abort");
        check_counters("abort");
        checks++;
        if (fill_level !== 10'd0) begin
            failures++;
            $display("FAIL abort_fill: fill_level=%0d, required 0", fill_level);
        end
    endtask

    task automatic test_oversize();
        fixed_ready = 1'b0;
        tick(2);
        saw_valid = 1'b0;
        ready_low = 1'b0;
        send_frame(600, 1'b0, 1'b0);
        tick(4);
        checks++;
        if (ready_low || saw_valid) begin
            failures++;
            $display("FAIL oversize_flow: tready_dropped=%b m_tvalid_seen=%b, required 0/0", ready_low, saw_valid);
        end
        check_counters("oversize");
        checks++;
        if (fill_level !== 10'd0) begin
            failures++;
            $display("FAIL oversize_fill: fill_level=%0d, required 0", fill_level);
        end
    endtask

    task automatic test_fill_full();
        for (int f = 0; f < 7; f++) send_frame(64, 1'b0, 1'b1);
        send_frame(100, 1'b0, 1'b0);
        tick(2);
        checks++;
        if (drop_frames !== DROP_BITS'(exp_drops)) begin
            failures++;
            $display("FAIL full_drop: drop_frames=%0d, required %0d", drop_frames, exp_drops);
        end
        fixed_ready = 1'b1;
        wait_drain(2000, "full");
        check_counters("full");
    endtask

    task automatic test_exact_depth();
        fixed_ready = 1'b0;
        tick(2);
        send_frame(513, 1'b0, 1'b0);
        tick(2);
        checks++;
        if (fill_level !== 10'd0 || drop_frames !== DROP_BITS'(exp_drops)) begin
            failures++;
            $display("FAIL depth513: fill=%0d drop=%0d, required 0/%0d", fill_level, drop_frames, exp_drops);
        end
        send_frame(512, 1'b0, 1'b1);
        checks++;
        if (fill_level !== 10'd512) begin
            failures++;
            $display("FAIL depth512_fill: fill_level=%0d right after commit, required 512", fill_level);
        end
        fixed_ready = 1'b1;
        wait_drain(2000, "depth512");
        check_counters("depth512");
    endtask

    task automatic test_random();
        int  n;
        int  len;
        bit  abort;
        rand_ready = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            n = 0;
            while (fill_level > 10'd448 && n < 20000) begin
                tick(1);
                n++;
            end
            if (n >= 20000) begin
                checks++;
                failures++;
                $display("FAIL random_stall: fill_level=%0d never fell to 448 before frame %0d", fill_level, f);
                break;
            end
            len   = $urandom_range(1, 64);
            abort = ($urandom_range(0, 15) == 0);
            send_frame(len, abort, !abort);
        end
        wait_drain(10000, "random");
        rand_ready = 1'b0;
        check_counters("random");
        checks++;
        if (fill_level !== 10'd0) begin
            failures++;
            $display("FAIL random_fill: fill_level=%0d, required 0", fill_level);
        end
    endtask

    task automatic test_reset_mid_frame();
        fixed_ready = 1'b1;
        tick(2);
        send_frame(20, 1'b0, 1'b1);
        tick(5);
        checks++;
        if (m_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre: m_axis_tvalid=%b mid-frame, required 1", m_tvalid);
        end
        resetn = 1'b0;
        sb.delete();
        exp_tx    = 0;
        exp_drops = 0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || fill_level !== 10'd0) begin
            failures++;
            $display("FAIL midreset_async: valid=%b fill=%0d during reset, required 0/0", m_tvalid, fill_level);
        end
        check_counters("midreset");
        tick(2);
        resetn = 1'b1;
        tick(2);
        send_frame(6, 1'b0, 1'b1);
        wait_drain(100, "postreset");
        check_counters("postreset");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_abort();
        test_oversize();
        test_fill_full();
        test_exact_depth();
        test_random();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
